linha_envase_ctrl: RTL and testbench



---
 rtl/linha_envase_ctrl_pkg.sv | 27 ++
 rtl/linha_envase_ctrl_sincronizador.sv | 42 ++++
 rtl/linha_envase_ctrl.sv | 179 +++++++++++++++++
 tb/tb_linha_envase_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linha_envase_ctrl_pkg.sv
// Shared definitions for the bottling-line sequencer: state encoding,
// fault codes and default timing values.
package linha_envase_ctrl_pkg;

  localparam int unsigned T_VEDACAO_DEF      = 50000;
  localparam int unsigned T_TIMEOUT_DEF      = 500000;
  localparam int unsigned GARRAFAS_DUZIA_DEF = 12;
  localparam int unsigned SYNC_STAGES_DEF    = 2;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    AVANCA   = 3'd1,
    ENCHENDO = 3'd2,
    VEDANDO  = 3'd3,
    LIBERA   = 3'd4,
    ERRO     = 3'd5
  } estado_e;

  localparam logic [1:0] ERR_NENHUM  = 2'b00;
  localparam logic [1:0] ERR_ROLHA   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/linha_envase_ctrl_sincronizador.sv
// Multi-flop synchroniser for one asynchronous input, with an optional
// rising-edge strobe taken from the synchronised level.
module sincronizador #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[SYNC_STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_q <= 1'b0;
      else          prev_q <= q_o;
    end

    assign rise_o = q_o & ~prev_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/linha_envase_ctrl.sv
// Bottling-line sequencer: synchronises switches/sensors, steps each bottle
// through advance, fill, seal and release, and emits cork/dozen pulses.
module linha_envase_ctrl
  import linha_envase_ctrl_pkg::*;
#(
  parameter int unsigned T_VEDACAO      = T_VEDACAO_DEF,
  parameter int unsigned T_TIMEOUT      = T_TIMEOUT_DEF,
  parameter int unsigned GARRAFAS_DUZIA = GARRAFAS_DUZIA_DEF,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_sw,
  input  logic       stop_sw,
  input  logic       sensor_garrafa,
  input  logic       sensor_nivel,
  input  logic       rolhas_ok,
  output logic       motor_esteira,
  output logic       valvula,
  output logic       vedador,
  output logic       pulso_rolha,
  output logic       pulso_duzia,
  output logic       alarme,
  output logic [1:0] erro_cod,
  output logic [2:0] estado
);

  localparam int unsigned TW = $clog2(max_u(T_VEDACAO, T_TIMEOUT));
  localparam int unsigned CW = $clog2(GARRAFAS_DUZIA);
  localparam logic [TW-1:0] VED_LAST = TW'(T_VEDACAO - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(T_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(GARRAFAS_DUZIA - 1);

  // Input synchronisers: bit 0 start (edge used), 1 stop, 2 bottle, 3 level.
  logic [3:0] raw_in, sync_lvl, sync_rise;
  logic [2:0] unused_rise;
  logic       start_ev, stop_s, garrafa_s, nivel_s;

  assign raw_in = {sensor_nivel, sensor_garrafa, stop_sw, start_sw};

  for (genvar g = 0; g < 4; g++) begin : g_sync
    sincronizador #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_EN    (g == 0)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (raw_in[g]),
      .q_o    (sync_lvl[g]),
      .rise_o (sync_rise[g])
    );
  end

  assign start_ev    = sync_rise[0];
  assign unused_rise = sync_rise[3:1];
  assign stop_s      = sync_lvl[1];
  assign garrafa_s   = sync_lvl[2];
  assign nivel_s     = sync_lvl[3];

  estado_e       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stop_req_q, stop_req_d;
  logic [1:0]    erro_q, erro_d;
  logic          motor_q, motor_d, valv_q, valv_d, ved_q, ved_d;
  logic          rolha_q, rolha_d, duzia_q, duzia_d, alarme_q, alarme_d;

  // Next state, shared timer, bottle counter, stop latch and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stop_req_d = stop_req_q;
    erro_d     = erro_q;
    rolha_d    = 1'b0;
    duzia_d    = 1'b0;
    timer_d    = '0;

    if (stop_s && (state_q == ENCHENDO || state_q == VEDANDO || state_q == LIBERA))
      stop_req_d = 1'b1;

    case (state_q)
      PARADO: begin
        // Stop wins over a simultaneous start edge.
        if (start_ev && rolhas_ok && !stop_s) state_d = AVANCA;
      end
      AVANCA: begin
        if (stop_s)         state_d = PARADO;
        else if (garrafa_s) state_d = ENCHENDO;
      end
      ENCHENDO: begin
        // Level beats timeout when both land in the same cycle.
        if (nivel_s) begin
          if (rolhas_ok) begin
            state_d = VEDANDO;
            rolha_d = 1'b1;
          end else begin
            state_d = ERRO;
            erro_d  = ERR_ROLHA;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = ERRO;
          erro_d  = ERR_TIMEOUT;
        end
      end
      VEDANDO: begin
        if (timer_q == VED_LAST) begin
          state_d = LIBERA;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            duzia_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LIBERA: begin
        if (!garrafa_s)
          state_d = (stop_req_q || stop_s || !rolhas_ok) ? PARADO : AVANCA;
      end
      ERRO: begin
        // Faulted bottle is ejected through LIBERA without being counted.
        if (start_ev && rolhas_ok) begin
          state_d = LIBERA;
          erro_d  = ERR_NENHUM;
        end
      end
      default: state_d = PARADO;
    endcase

    if (state_d == PARADO) stop_req_d = 1'b0;

    if (state_d == state_q && (state_q == ENCHENDO || state_q == VEDANDO))
      timer_d = timer_q + 1'b1;

    motor_d  = (state_d == AVANCA) || (state_d == LIBERA);
    valv_d   = (state_d == ENCHENDO);
    ved_d    = (state_d == VEDANDO);
    alarme_d = (state_d == ERRO);
  end

  // State, timer, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PARADO;
      timer_q    <= '0;
      cnt_q      <= '0;
      stop_req_q <= 1'b0;
      erro_q     <= ERR_NENHUM;
      motor_q    <= 1'b0;
      valv_q     <= 1'b0;
      ved_q      <= 1'b0;
      rolha_q    <= 1'b0;
      duzia_q    <= 1'b0;
      alarme_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      stop_req_q <= stop_req_d;
      erro_q     <= erro_d;
      motor_q    <= motor_d;
      valv_q     <= valv_d;
      ved_q      <= ved_d;
      rolha_q    <= rolha_d;
      duzia_q    <= duzia_d;
      alarme_q   <= alarme_d;
    end
  end

  assign motor_esteira = motor_q;
  assign valvula       = valv_q;
  assign vedador       = ved_q;
  assign pulso_rolha   = rolha_q;
  assign pulso_duzia   = duzia_q;
  assign alarme        = alarme_q;
  assign erro_cod      = erro_q;
  assign estado        = state_q;

endmodule

// File: tb/tb_linha_envase_ctrl.sv
// Directed bench for the bottling-line sequencer (T_VEDACAO=4, T_TIMEOUT=20).
module tb_linha_envase_ctrl;

  localparam logic [2:0] S_PARADO = 3'd0, S_AVANCA = 3'd1, S_ENCHENDO = 3'd2,
                         S_VEDANDO = 3'd3, S_LIBERA = 3'd4, S_ERRO = 3'd5;

  logic clk = 1'b0;
  logic reset_n, start_sw, stop_sw, sensor_garrafa, sensor_nivel, rolhas_ok;
  logic motor_esteira, valvula, vedador, pulso_rolha, pulso_duzia, alarme;
  logic [1:0] erro_cod;
  logic [2:0] estado;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  linha_envase_ctrl #(
    .T_VEDACAO(4), .T_TIMEOUT(20), .GARRAFAS_DUZIA(12), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_sw(start_sw), .stop_sw(stop_sw),
    .sensor_garrafa(sensor_garrafa), .sensor_nivel(sensor_nivel),
    .rolhas_ok(rolhas_ok), .motor_esteira(motor_esteira), .valvula(valvula),
    .vedador(vedador), .pulso_rolha(pulso_rolha), .pulso_duzia(pulso_duzia),
    .alarme(alarme), .erro_cod(erro_cod), .estado(estado)
  );

  always #5 clk = ~clk;

  assign outs = {motor_esteira, valvula, vedador, pulso_rolha, pulso_duzia,
                 alarme, erro_cod, estado};

  // Pulse and sealing-window monitor, sampled on the falling edge.
  int n_rolha = 0, n_duzia = 0, n_overlap = 0, n_wide = 0;
  int ved_run = 0, last_ved = 0;
  logic prev_r = 1'b0, prev_d = 1'b0, prev_v = 1'b0;

  always @(negedge clk) begin
    if (pulso_rolha) n_rolha++;
    if (pulso_duzia) n_duzia++;
    if (pulso_rolha && pulso_duzia) n_overlap++;
    if ((pulso_rolha && prev_r) || (pulso_duzia && prev_d)) n_wide++;
    if (vedador) ved_run++;
    else if (prev_v) begin
      last_ved = ved_run;
      ved_run  = 0;
    end
    prev_r = pulso_rolha;
    prev_d = pulso_duzia;
    prev_v = vedador;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete bottle starting from AVANCA and returning to AVANCA.
  task automatic do_bottle(input logic exp_duzia);
    sensor_garrafa = 1'b1;
    tick(3);
    chk("bottle_fill", {29'd0, estado}, {29'd0, S_ENCHENDO});
    sensor_nivel = 1'b1;
    tick(3);
    chk("bottle_seal", {29'd0, estado}, {29'd0, S_VEDANDO});
    chk("bottle_no_duzia_on_seal", {31'd0, pulso_duzia}, 32'd0);
    sensor_nivel = 1'b0;
    tick(4);
    chk("bottle_release", {29'd0, estado}, {29'd0, S_LIBERA});
    chk("bottle_duzia", {31'd0, pulso_duzia}, {31'd0, exp_duzia});
    sensor_garrafa = 1'b0;
    tick(3);
    chk("bottle_advance", {29'd0, estado}, {29'd0, S_AVANCA});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_d;
    start_sw = 0; stop_sw = 0; sensor_garrafa = 0; sensor_nivel = 0; rolhas_ok = 1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(3);
    chk("reset_outs", {21'd0, outs}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Reset in the middle of a fill.
    start_sw = 1'b1;
    tick(3);
    chk("start_avanca", {29'd0, estado}, {29'd0, S_AVANCA});
    chk("start_motor", {31'd0, motor_esteira}, 32'd1);
    start_sw = 1'b0;
    sensor_garrafa = 1'b1;
    tick(3);
    chk("enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    chk("enchendo_valve", {31'd0, valvula}, 32'd1);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", {21'd0, outs}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("idle_after_reset", {21'd0, outs}, 32'd0);

    // Normal cycle, level after 6 fill cycles.
    start_sw = 1'b1;
    tick(3);
    chk("normal_avanca", {29'd0, estado}, {29'd0, S_AVANCA});
    start_sw = 1'b0;
    tick(1);
    chk("normal_enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    base_r = n_rolha;
    tick(3);
    sensor_nivel = 1'b1;
    tick(3);
    chk("normal_vedando", {29'd0, estado}, {29'd0, S_VEDANDO});
    chk("normal_vedador", {31'd0, vedador}, 32'd1);
    chk("normal_pulso_rolha", {31'd0, pulso_rolha}, 32'd1);
    sensor_nivel = 1'b0;
    tick(1);
    chk("normal_rolha_width", {31'd0, pulso_rolha}, 32'd0);
    tick(3);
    chk("normal_libera", {29'd0, estado}, {29'd0, S_LIBERA});
    chk("normal_ved_off", {31'd0, vedador}, 32'd0);
    chk("normal_libera_motor", {31'd0, motor_esteira}, 32'd1);
    sensor_garrafa = 1'b0;
    tick(3);
    chk("normal_back_avanca", {29'd0, estado}, {29'd0, S_AVANCA});
    chk("normal_rolha_count", n_rolha - base_r, 32'd1);
    chk("normal_ved_len", last_ved, 32'd4);

    // Cork out at level.
    sensor_garrafa = 1'b1;
    tick(3);
    chk("cork_enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    rolhas_ok = 1'b0;
    sensor_nivel = 1'b1;
    base_r = n_rolha;
    tick(3);
    chk("cork_erro", {29'd0, estado}, {29'd0, S_ERRO});
    chk("cork_alarme", {31'd0, alarme}, 32'd1);
    chk("cork_cod", {30'd0, erro_cod}, 32'd1);
    sensor_nivel = 1'b0;
    rolhas_ok = 1'b1;
    start_sw = 1'b1;
    tick(3);
    chk("cork_libera", {29'd0, estado}, {29'd0, S_LIBERA});
    chk("cork_cod_clear", {30'd0, erro_cod}, 32'd0);
    chk("cork_alarme_clear", {31'd0, alarme}, 32'd0);
    start_sw = 1'b0;
    sensor_garrafa = 1'b0;
    tick(3);
    chk("cork_avanca", {29'd0, estado}, {29'd0, S_AVANCA});
    chk("cork_no_rolha", n_rolha - base_r, 32'd0);

    // Fill timeout: ERRO exactly 20 cycles after ENCHENDO entry.
    sensor_garrafa = 1'b1;
    tick(3);
    chk("to_enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    tick(19);
    chk("to_still_filling", {29'd0, estado}, {29'd0, S_ENCHENDO});
    tick(1);
    chk("to_erro", {29'd0, estado}, {29'd0, S_ERRO});
    chk("to_cod", {30'd0, erro_cod}, 32'd2);
    chk("to_valve_off", {31'd0, valvula}, 32'd0);
    start_sw = 1'b1;
    tick(3);
    chk("to_libera", {29'd0, estado}, {29'd0, S_LIBERA});
    start_sw = 1'b0;
    sensor_garrafa = 1'b0;
    tick(3);
    chk("to_avanca", {29'd0, estado}, {29'd0, S_AVANCA});

    // Level and timeout in the same cycle: level wins.
    sensor_garrafa = 1'b1;
    tick(3);
    chk("tie_enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    tick(17);
    sensor_nivel = 1'b1;
    tick(3);
    chk("tie_vedando", {29'd0, estado}, {29'd0, S_VEDANDO});
    chk("tie_cod", {30'd0, erro_cod}, 32'd0);
    sensor_nivel = 1'b0;
    tick(4);
    chk("tie_libera", {29'd0, estado}, {29'd0, S_LIBERA});
    sensor_garrafa = 1'b0;
    tick(3);
    chk("tie_avanca", {29'd0, estado}, {29'd0, S_AVANCA});

    // Two bottles counted so far; the dozen closes on the 10th from here.
    base_d = n_duzia;
    for (int i = 0; i < 9; i++) do_bottle(1'b0);
    chk("dozen_none_yet", n_duzia - base_d, 32'd0);
    do_bottle(1'b1);
    chk("dozen_first", n_duzia - base_d, 32'd1);
    for (int i = 0; i < 11; i++) do_bottle(1'b0);
    do_bottle(1'b1);
    chk("dozen_second", n_duzia - base_d, 32'd2);
    chk("pulse_overlap", n_overlap, 32'd0);
    chk("pulse_width", n_wide, 32'd0);

    // Stop during sealing: seal completes, bottle released, then PARADO.
    sensor_garrafa = 1'b1;
    tick(3);
    chk("stop_enchendo", {29'd0, estado}, {29'd0, S_ENCHENDO});
    sensor_nivel = 1'b1;
    tick(3);
    chk("stop_vedando", {29'd0, estado}, {29'd0, S_VEDANDO});
    sensor_nivel = 1'b0;
    stop_sw = 1'b1;
    tick(4);
    chk("stop_libera", {29'd0, estado}, {29'd0, S_LIBERA});
    sensor_garrafa = 1'b0;
    tick(3);
    chk("stop_parado", {29'd0, estado}, {29'd0, S_PARADO});
    chk("stop_motor_off", {31'd0, motor_esteira}, 32'd0);
    chk("stop_ved_len", last_ved, 32'd4);
    start_sw = 1'b1;
    tick(5);
    chk("start_and_stop", {29'd0, estado}, {29'd0, S_PARADO});
    start_sw = 1'b0;
    stop_sw = 1'b0;
    tick(3);
    start_sw = 1'b1;
    tick(3);
    chk("restart_avanca", {29'd0, estado}, {29'd0, S_AVANCA});
    start_sw = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
